// File: rtl/sram_model_pkg.sv
// Shared types and elaboration helpers for the 1rw1r SRAM model.
// Holds sweeper state encoding, segment sizing and config checks.
package sram_model_pkg;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int write_size(input int dw, input int mw);
      return dw / mw;
   endfunction

   function automatic bit words_ok(input int aw, input int nw);
      return (nw > 0) && (clog2(nw) <= aw);
   endfunction

   function automatic bit mask_ok(input int dw, input int mw);
      return (mw > 0) && ((dw % mw) == 0);
   endfunction

endpackage

// File: rtl/sram_init_sweeper.sv
// Post-reset clear sweep: walks every word once, then holds READY.
// Drives the clear write strobe/address and the init_done flag.
module sram_init_sweeper
   import sram_model_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int NUM_WORDS  = 48,
   parameter int INIT_CLEAR = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  init_done
);

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [ADDR_WIDTH-1:0] cnt_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= (INIT_CLEAR != 0) ? S_CLEAR : S_READY;
         cnt       <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         init_done <= (state_nxt == S_READY);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      clr_we    = 1'b0;
      unique case (state)
         S_CLEAR: begin
            clr_we = ~rst;
            if (cnt == LAST) begin
               state_nxt = S_READY;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         S_READY: ;
         default: ;
      endcase
   end

   assign clr_addr = cnt;

endmodule

// File: rtl/sram_1rw1r_wmask_model.sv
// 1rw1r SRAM model with write mask, odd depth and post-reset clear.
// Port 1 is read-first against a same-address port 0 write.
module sram_1rw1r_wmask_model
   import sram_model_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 6,
   parameter int NUM_WORDS   = 48,
   parameter int WMASK_WIDTH = 4,
   parameter int INIT_CLEAR  = 1,
   parameter int VERBOSE     = 1
) (
   input  logic                   clk0,
   input  logic                   rst0,
   output logic                   init_done,
   input  logic                   csb0,
   input  logic                   web0,
   input  logic [WMASK_WIDTH-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0]  addr0,
   input  logic [DATA_WIDTH-1:0]  din0,
   output logic [DATA_WIDTH-1:0]  dout0,
   output logic                   dout0_valid,
   input  logic                   csb1,
   input  logic [ADDR_WIDTH-1:0]  addr1,
   output logic [DATA_WIDTH-1:0]  dout1,
   output logic                   dout1_valid,
   output logic                   collision,
   output logic                   addr_err
);

   localparam int WS = write_size(DATA_WIDTH, WMASK_WIDTH);
   localparam logic [ADDR_WIDTH:0] NW = (ADDR_WIDTH + 1)'(NUM_WORDS);

   if (!words_ok(ADDR_WIDTH, NUM_WORDS)) begin : g_bad_words
      $error("NUM_WORDS must be in 1..2**ADDR_WIDTH");
   end
   if (!mask_ok(DATA_WIDTH, WMASK_WIDTH)) begin : g_bad_mask
      $error("WMASK_WIDTH must divide DATA_WIDTH");
   end

   logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  acc;
   logic                  rd0;
   logic                  wr0;
   logic                  rd1;
   logic                  ok0;
   logic                  ok1;
   logic                  col_c;
   logic                  err_c;

   sram_init_sweeper #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WORDS  (NUM_WORDS),
      .INIT_CLEAR (INIT_CLEAR)
   ) u_sweeper (
      .clk       (clk0),
      .rst       (rst0),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr),
      .init_done (init_done)
   );

   assign acc   = init_done & ~rst0;
   assign rd0   = acc & ~csb0 & web0;
   assign wr0   = acc & ~csb0 & ~web0;
   assign rd1   = acc & ~csb1;
   assign ok0   = {1'b0, addr0} < NW;
   assign ok1   = {1'b0, addr1} < NW;
   assign col_c = wr0 & rd1 & (addr0 == addr1);
   assign err_c = (acc & ~csb0 & ~ok0) | (rd1 & ~ok1);

   // Clear sweep and user writes never overlap: requests wait for init_done.
   always_ff @(posedge clk0) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (wr0 && ok0) begin
         for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (wmask0[i]) mem[addr0][i*WS +: WS] <= din0[i*WS +: WS];
         end
      end
   end

   always_ff @(posedge clk0) begin
      if (rst0) begin
         dout0       <= '0;
         dout1       <= '0;
         dout0_valid <= 1'b0;
         dout1_valid <= 1'b0;
         collision   <= 1'b0;
         addr_err    <= 1'b0;
      end else begin
         dout0_valid <= rd0;
         dout1_valid <= rd1;
         collision   <= col_c;
         addr_err    <= err_c;
         if (rd0) dout0 <= ok0 ? mem[addr0] : '0;
         if (rd1) dout1 <= ok1 ? mem[addr1] : '0;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk0) begin
      if (col_c)
         $display("%0t %m: warning port collision addr %0d", $time, addr0);
      if (err_c)
         $display("%0t %m: warning address error a0=%0d a1=%0d",
                  $time, addr0, addr1);
      if (VERBOSE != 0) begin
         if (rd0) $display("%0t %m: p0 read  addr %0d", $time, addr0);
         if (wr0) $display("%0t %m: p0 write addr %0d data %h mask %b",
                           $time, addr0, din0, wmask0);
         if (rd1) $display("%0t %m: p1 read  addr %0d", $time, addr1);
      end
   end
`endif

endmodule
